// File: rtl/alu_exec_unit.sv
// Single-issue ALU: one-cycle logic/shift/add ops, and a 32-cycle iterative multiplier.
// Each result is held in DONE until the consumer takes it.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             busy_o
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [WIDTH-1:0] acc_step;
  logic [SHW-1:0]   shamt;

  assign shamt = data2_i[SHW-1:0];

  // Single-cycle ops, evaluated straight from the inputs at the accept edge
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (ALUCtrl_i)
      4'd1:    alu_res = data1_i & data2_i;
      4'd2:    alu_res = data1_i ^ data2_i;
      4'd3:    alu_res = data1_i << shamt;
      4'd4:    alu_res = data1_i + data2_i;
      4'd5:    alu_res = data1_i - data2_i;
      4'd6:    alu_res = '0;
      4'd7:    alu_res = $signed(data1_i) >>> shamt;
      4'd8:    alu_res = data1_i | data2_i;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (ALUCtrl_i == 4'd6) begin
            state_d  = MUL;
            cnt_d    = '0;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            err_d    = alu_illegal;
          end
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first; low WIDTH bits only
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d  = DONE;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          err_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] d1, d2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, err, busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ALUCtrl_i(ctrl), .data1_i(d1), .data2_i(d2), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .zero_o(zero), .err_o(err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    ctrl = c; d1 = a; d2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ctrl = 4'd0; d1 = 32'hDEAD_BEEF; d2 = 32'h1234_5678;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", {31'd0, out_valid}, 32'd0);
    chk("consume_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] r, input logic z, input logic e);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ctrl = 4'd0; d1 = '0; d2 = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // add wraps to zero
    issue(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
    chk_done("add", 32'h0, 1'b1, 1'b0);
    chk("add_inrdy", {31'd0, in_ready}, 32'd0);
    consume();
    chk("add_zero_clr", {31'd0, zero}, 32'd0);

    issue(4'd7, 32'h8000_0000, 32'h0000_0024);
    chk_done("srai", 32'hF800_0000, 1'b0, 1'b0);
    consume();
    issue(4'd3, 32'h0000_0001, 32'h0000_001F);
    chk_done("sll", 32'h8000_0000, 1'b0, 1'b0);
    consume();
    issue(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk_done("and", 32'hF000_F000, 1'b0, 1'b0);
    consume();
    issue(4'd2, 32'hAAAA_5555, 32'hFFFF_0000);
    chk_done("xor", 32'h5555_5555, 1'b0, 1'b0);
    consume();
    issue(4'd8, 32'h0000_0F00, 32'h0000_00F0);
    chk_done("or", 32'h0000_0FF0, 1'b0, 1'b0);
    consume();

    // mul: 31 MUL cycles observed without a result, then DONE on the 32nd edge
    issue(4'd6, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("mul_busy0", {31'd0, busy}, 32'd1);
    chk("mul_valid0", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 31; i++) begin
      if (i == 10) begin ctrl = 4'd4; d1 = 32'd1; d2 = 32'd1; in_valid = 1'b1; end
      if (i == 12) in_valid = 1'b0;
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        chk("mul_inflight_valid", {31'd0, out_valid}, 32'd0);
        chk("mul_inflight_busy", {31'd0, busy}, 32'd1);
      end
    end
    chk("mul_valid31", {31'd0, out_valid}, 32'd0);
    tick();
    chk_done("mul", 32'hFFFF_FFEB, 1'b0, 1'b0);
    consume();

    // backpressure: sub result held while the consumer stalls
    issue(4'd5, 32'd5, 32'd7);
    for (int i = 0; i < 10; i++) begin
      d1 = 32'(i); d2 = 32'(3 * i);
      tick();
    end
    chk_done("sub_hold", 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk("sub_inrdy", {31'd0, in_ready}, 32'd0);
    consume();

    issue(4'hA, 32'd5, 32'd3);
    chk_done("illegal", 32'h0, 1'b1, 1'b1);
    consume();
    chk("illegal_err_clr", {31'd0, err}, 32'd0);

    // reset in the middle of a multiply discards it
    issue(4'd6, 32'd3, 32'd4);
    for (int i = 0; i < 14; i++) tick();
    chk("rmul_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmul_valid", {31'd0, out_valid}, 32'd0);
    chk("rmul_busy_clr", {31'd0, busy}, 32'd0);
    chk("rmul_ready", {31'd0, in_ready}, 32'd1);
    issue(4'd4, 32'd2, 32'd3);
    chk_done("post_rst_add", 32'd5, 1'b0, 1'b0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits; only 32 is required to be supported.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 in_valid_i  input  1  operation request valid.
REQ-005 in_ready_o  output  1  block can accept a request.
REQ-006 ALUCtrl_i  input  4  operation code from ALU_Control: 1 and, 2 xor, 3 sll, 4 add, 5 sub, 6 mul, 7 srai, 8 or.
REQ-007 data1_i  input  WIDTH  operand A (rs1).
REQ-008 data2_i  input  WIDTH  operand B (rs2 or immediate).
REQ-009 out_valid_o  output  1  result valid.
REQ-010 out_ready_i  input  1  consumer accepts result.
REQ-011 result_o  output  WIDTH  operation result.
REQ-012 zero_o  output  1  high when result_o == 0, valid with out_valid_o.
REQ-013 err_o  output  1  unsupported ALUCtrl_i code, valid with out_valid_o.
REQ-014 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-015 State machine SHALL have states IDLE, MUL, DONE; in_ready_o SHALL equal (state == IDLE).
REQ-016 Accept = in_valid_i && in_ready_o at a rising edge; opcode and operands SHALL be captured only on accept and held internally; later input changes SHALL be ignored.
REQ-017 Non-mul accept: IDLE -> DONE; result computed and registered at the accept edge; out_valid_o high the following cycle (latency 1).
REQ-018 and/xor/or/add/sub: bitwise or modulo-2^WIDTH arithmetic, carry and overflow discarded.
REQ-019 sll: data1 << data2[4:0]; srai: data1 arithmetic right shift by data2[4:0] (sign fill); data2[WIDTH-1:5] ignored.
REQ-020 mul accept: IDLE -> MUL; 5-bit counter cleared; iterative shift-add, one multiplier bit per cycle, LSB first.
REQ-021 MUL: after exactly 32 MUL cycles -> DONE; out_valid_o first high 32 cycles after the accept edge; result = low WIDTH bits of data1*data2 (signed and unsigned identical).
REQ-022 Unsupported code (0, 9-15): IDLE -> DONE, result_o = 0, zero_o = 1, err_o = 1; latency 1.
REQ-023 DONE: out_valid_o = 1; result_o, zero_o, err_o held stable until out_ready_i is sampled high; then -> IDLE.
REQ-024 out_ready_i SHALL be ignored outside DONE; in_valid_i SHALL be ignored outside IDLE.
REQ-025 Back-to-back: minimum 2 cycles between accepts (IDLE, DONE); no request SHALL be accepted in the same cycle a result is consumed.
REQ-026 out_valid_o SHALL be low in IDLE and MUL; err_o and zero_o SHALL be low whenever out_valid_o is low.

Reset
REQ-027 With rst_i high at a rising edge: state = IDLE, counter = 0, result_o = 0, out_valid_o = 0, zero_o = 0, err_o = 0, busy_o = 0; in_ready_o = 1 the next cycle.
REQ-028 Reset SHALL take priority over all events: an in-flight MUL or a held DONE result is discarded, and any accept in the reset cycle is lost.

Verification
REQ-029 add: accept ALUCtrl=4, 0xFFFFFFFF + 0x00000001 -> next cycle out_valid_o=1, result 0x00000000, zero_o=1, err_o=0.
REQ-030 srai/sll: ALUCtrl=7, 0x80000000, shamt 0x24 (uses 4) -> 0xF8000000; ALUCtrl=3, 0x1, 0x1F -> 0x80000000.
REQ-031 mul: ALUCtrl=6, 0xFFFFFFFD (-3) x 0x00000007 -> busy_o high for 32 cycles, then result 0xFFFFFFEB; in_valid_i pulsed during MUL is ignored.
REQ-032 Backpressure: sub 5-7 with out_ready_i=0 for 10 cycles -> result 0xFFFFFFFE held, in_ready_o=0; out_ready_i=1 -> IDLE next cycle.
REQ-033 Illegal code: ALUCtrl=0xA -> result 0, err_o=1, zero_o=1, latency 1.
REQ-034 Reset mid-mul: rst_i high at MUL cycle 15 -> next cycle out_valid_o=0, busy_o=0, in_ready_o=1; a following add 2+3 returns 5.
